// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the register responder.
// The master modport drives requests and the slave modport drives responses.
interface axi4_lite_reg_slave_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite responder over a bank of 32-bit read/write registers with byte strobes,
// SLVERR on out-of-range addresses and a one-cycle write pulse per register.
module axi4_lite_reg_slave #(
   parameter int unsigned NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     arst_n,
   axi4_lite_reg_slave_if.slave     s_axi,
   output logic [NUM_REGS*32-1:0]   reg_q,
   output logic [NUM_REGS-1:0]      reg_wr_pulse
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

   logic [31:0] regs [NUM_REGS];

   logic        aw_hold, w_hold;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;
   logic        bvalid_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;

   logic             aw_hs, w_hs, ar_hs, commit;
   logic [31:0]      wr_addr, wr_data, wr_off, rd_off;
   logic [3:0]       wr_strb;
   logic             wr_in, rd_in;
   logic [IDX_W-1:0] wr_idx, rd_idx;

   assign s_axi.awready = !aw_hold && !bvalid_q;
   assign s_axi.wready  = !w_hold && !bvalid_q;
   assign s_axi.arready = !rvalid_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   assign aw_hs  = s_axi.awvalid && s_axi.awready;
   assign w_hs   = s_axi.wvalid && s_axi.wready;
   assign ar_hs  = s_axi.arvalid && s_axi.arready;
   // Commit as soon as an address and data are both present, held or handshaking.
   assign commit = (aw_hold || aw_hs) && (w_hold || w_hs);

   assign wr_addr = aw_hold ? aw_addr_q : s_axi.awaddr;
   assign wr_data = w_hold ? w_data_q : s_axi.wdata;
   assign wr_strb = w_hold ? w_strb_q : s_axi.wstrb;

   // Modular subtraction makes addresses below BASE_ADDR wrap to out of range.
   assign wr_off = wr_addr - BASE_ADDR;
   assign wr_in  = wr_off < SPAN;
   assign wr_idx = wr_off[IDX_W+1:2];
   assign rd_off = s_axi.araddr - BASE_ADDR;
   assign rd_in  = rd_off < SPAN;
   assign rd_idx = rd_off[IDX_W+1:2];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < int'(NUM_REGS); k++) regs[k] <= '0;
         aw_hold      <= 1'b0;
         w_hold       <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= 2'b00;
         rvalid_q     <= 1'b0;
         rresp_q      <= 2'b00;
         rdata_q      <= '0;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;

         if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;

         if (commit) begin
            aw_hold  <= 1'b0;
            w_hold   <= 1'b0;
            bvalid_q <= 1'b1;
            if (wr_in) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
               end
               bresp_q              <= 2'b00;
               reg_wr_pulse[wr_idx] <= 1'b1;
            end else begin
               bresp_q <= 2'b10;
            end
         end else begin
            if (aw_hs) begin
               aw_hold   <= 1'b1;
               aw_addr_q <= s_axi.awaddr;
            end
            if (w_hs) begin
               w_hold   <= 1'b1;
               w_data_q <= s_axi.wdata;
               w_strb_q <= s_axi.wstrb;
            end
         end

         if (rvalid_q && s_axi.rready) rvalid_q <= 1'b0;

         // Nonblocking read of regs returns the pre-write value on a same-edge commit.
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_in ? regs[rd_idx] : 32'h0;
            rresp_q  <= rd_in ? 2'b00 : 2'b10;
         end
      end
   end

   for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg_out
      assign reg_q[32*k +: 32] = regs[k];
   end

endmodule
